// File: rtl/fifo_pkg.sv
// Shared sizing and read-FSM encoding for the FIFO pointer/flag controller.
package fifo_pkg;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;
endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer: AW index bits plus an MSB wrap bit that tells full from empty.
module fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [AW:0] ptr
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO occupancy/flag controller with a read front-end that hides the array's 1-cycle read latency.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = fifo_pkg::DEPTH,
  parameter int AW    = fifo_pkg::AW,
  parameter int DW    = fifo_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          en_write,
  output logic [AW:0]   ptr_in,
  output logic [DW-1:0] mem_wdata,
  output logic          en_read,
  output logic [AW:0]   ptr_out,
  input  logic [DW-1:0] mem_rdata,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW+1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  rd_state_e   state, state_nxt;
  logic [AW:0] stored;
  logic        arr_empty;

  // Flags come only from registered pointers, so a same-cycle read never frees a slot for a write.
  assign stored    = ptr_in - ptr_out;
  assign full      = (stored == DEPTH_P);
  assign arr_empty = (stored == '0);
  assign wr_ready  = !full;
  assign en_write  = wr_valid && wr_ready && reset;
  assign mem_wdata = wr_data;
  assign rd_valid  = (state == HOLD);
  assign count     = {1'b0, stored} + (AW+2)'(state != IDLE);
  assign empty     = (count == '0);

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (en_write),
    .ptr   (ptr_in)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (en_read),
    .ptr   (ptr_out)
  );

  always_comb begin
    state_nxt = state;
    en_read   = 1'b0;
    case (state)
      IDLE: begin
        if (!arr_empty) begin
          en_read   = reset;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        if (rd_ready) begin
          if (!arr_empty) begin
            en_read   = reset;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) rd_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 16x8 array beside it.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       en_write;
  logic [4:0] ptr_in;
  logic [7:0] mem_wdata;
  logic       en_read;
  logic [4:0] ptr_out;
  logic [7:0] mem_rdata = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic       full;
  logic       empty;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  // Storage array: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (en_write) mem[ptr_in[3:0]] <= mem_wdata;
    if (en_read)  mem_rdata <= mem[ptr_out[3:0]];
  end

  fifo_ctrl dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .en_write(en_write), .ptr_in(ptr_in), .mem_wdata(mem_wdata),
    .en_read(en_read), .ptr_out(ptr_out), .mem_rdata(mem_rdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (ptr_in !== 5'd0)   begin n_err++; $display("FAIL rst_ptr_in got %0d exp 0", ptr_in); end
    n_cmp++; if (ptr_out !== 5'd0)  begin n_err++; $display("FAIL rst_ptr_out got %0d exp 0", ptr_out); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data got %h exp 00", rd_data); end
    n_cmp++; if (count !== 6'd0)    begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (full !== 1'b0 || empty !== 1'b1 || wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_flags got full=%b empty=%b wr_ready=%b exp 0 1 1", full, empty, wr_ready); end
    n_cmp++; if (en_read !== 1'b0 || en_write !== 1'b0) begin n_err++; $display("FAIL rst_strobes got en_read=%b en_write=%b exp 0 0", en_read, en_write); end
    tick();
  endtask

  task automatic test_single_byte();
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    n_cmp++; if (en_write !== 1'b1 || ptr_in !== 5'd0) begin n_err++; $display("FAIL single_write got en_write=%b ptr_in=%0d exp 1 0", en_write, ptr_in); end
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (en_read !== 1'b1 || ptr_out !== 5'd0) begin n_err++; $display("FAIL single_en_read got en_read=%b ptr_out=%0d exp 1 0", en_read, ptr_out); end
    tick();
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b0 || count !== 6'd1) begin n_err++; $display("FAIL single_fetch got rd_valid=%b count=%0d exp 0 1", rd_valid, count); end
    tick();
    @(negedge clk);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_err++; $display("FAIL single_out got rd_valid=%b rd_data=%h exp 1 a5", rd_valid, rd_data); end
    rd_ready = 1'b1;
    tick(); rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1 || rd_valid !== 1'b0 || count !== 6'd0) begin n_err++; $display("FAIL single_drained got empty=%b rd_valid=%b count=%0d exp 1 0 0", empty, rd_valid, count); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i <= 16; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      @(negedge clk);
      n_cmp++; if (en_write !== 1'b1) begin n_err++; $display("FAIL fill_accept[%0d] got en_write=%b exp 1", i, en_write); end
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 6'd17) begin n_err++; $display("FAIL fill_flags got full=%b wr_ready=%b count=%0d exp 1 0 17", full, wr_ready, count); end
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin n_err++; $display("FAIL fill_head got rd_valid=%b rd_data=%h exp 1 00", rd_valid, rd_data); end
    n_cmp++; if (ptr_in !== 5'd18) begin n_err++; $display("FAIL fill_ptr_in got %0d exp 18", ptr_in); end
    tick();
    wr_valid = 1'b1; wr_data = 8'h11;
    @(negedge clk);
    n_cmp++; if (en_write !== 1'b0) begin n_err++; $display("FAIL fill_refuse got en_write=%b exp 0", en_write); end
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ptr_in !== 5'd18) begin n_err++; $display("FAIL fill_ptr_hold got %0d exp 18", ptr_in); end
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'h00 || en_read !== 1'b0 || rd_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got rd_data=%h en_read=%b rd_valid=%b exp 00 0 1", i, rd_data, en_read, rd_valid); end
      tick();
    end
  endtask

  task automatic test_full_simultaneous();
    wr_valid = 1'b1; wr_data = 8'h11; rd_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (en_read !== 1'b1 || en_write !== 1'b0) begin n_err++; $display("FAIL simul_cycle0 got en_read=%b en_write=%b exp 1 0", en_read, en_write); end
    tick(); rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (en_write !== 1'b1 || ptr_in !== 5'd18 || wr_ready !== 1'b1) begin n_err++; $display("FAIL simul_cycle1 got en_write=%b ptr_in=%0d wr_ready=%b exp 1 18 1", en_write, ptr_in, wr_ready); end
    tick(); wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ptr_in !== 5'd19 || full !== 1'b1 || count !== 6'd17 || rd_data !== 8'h01) begin n_err++; $display("FAIL simul_after got ptr_in=%0d full=%b count=%0d rd_data=%h exp 19 1 17 01", ptr_in, full, count, rd_data); end
    tick();
  endtask

  task automatic test_drain();
    rd_ready = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      int w = 0;
      @(negedge clk);
      while (!rd_valid && w < 8) begin @(negedge clk); w++; end
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'(e)) begin n_err++; $display("FAIL drain[%0d] got rd_valid=%b rd_data=%h exp 1 %h", e, rd_valid, rd_data, 8'(e)); end
      tick();
    end
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1 || count !== 6'd0 || ptr_out !== 5'd19) begin n_err++; $display("FAIL drain_end got empty=%b count=%0d ptr_out=%0d exp 1 0 19", empty, count, ptr_out); end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [4:0] prev_ptr;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit wrapped = 1'b0;
    prev_ptr = ptr_in;
    while ((sent < 40 || q.size() != 0) && cyc < 3000) begin
      wr_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
      wr_data  = 8'(8'h40 + sent);
      rd_ready = (sent >= 40) || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n_cmp++; if (count !== 6'(q.size()) || empty !== (q.size() == 0)) begin n_err++; $display("FAIL wrap_count cyc %0d got count=%0d empty=%b exp %0d", cyc, count, empty, q.size()); end
      if (q.size() < 16) begin
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL wrap_full cyc %0d got full=1 exp 0 (held %0d)", cyc, q.size()); end
      end
      if (prev_ptr == 5'd31 && ptr_in == 5'd0) wrapped = 1'b1;
      prev_ptr = ptr_in;
      if (rd_valid && rd_ready) begin
        exp_b = (q.size() != 0) ? q.pop_front() : 8'hxx;
        n_cmp++; if (rd_data !== exp_b) begin n_err++; $display("FAIL wrap_order[%0d] got %h exp %h", got, rd_data, exp_b); end
        got++;
      end
      if (en_write) begin q.push_back(wr_data); sent++; end
      tick();
      cyc++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_cmp++; if (got != 40) begin n_err++; $display("FAIL wrap_total got %0d exp 40", got); end
    @(negedge clk);
    n_cmp++; if (!wrapped || ptr_in !== 5'd27 || ptr_out !== 5'd27) begin n_err++; $display("FAIL wrap_ptrs got wrapped=%b ptr_in=%0d ptr_out=%0d exp 1 27 27", wrapped, ptr_in, ptr_out); end
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (count !== 6'd5) begin n_err++; $display("FAIL mid_pre_count got %0d exp 5", count); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (count !== 6'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_err++; $display("FAIL mid_reset_out got count=%0d rd_valid=%b rd_data=%h exp 0 0 00", count, rd_valid, rd_data); end
    n_cmp++; if (ptr_in !== 5'd0 || ptr_out !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ptrs got ptr_in=%0d ptr_out=%0d empty=%b full=%b wr_ready=%b exp 0 0 1 0 1", ptr_in, ptr_out, empty, full, wr_ready); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1 || count !== 6'd0 || en_read !== 1'b0) begin n_err++; $display("FAIL mid_release got empty=%b count=%0d en_read=%b exp 1 0 0", empty, count, en_read); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill();
    test_backpressure();
    test_full_simultaneous();
    test_drain();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
